// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        FINISH
    } ccff_ld_state_e;

    // Bitstream words the host must supply for one full pass over the chain.
    function automatic int words_per_pass(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_serializer.sv
// Word-to-serial converter: one word buffered at a time, shifted out LSB first,
// with one bubble cycle between words while the next word is accepted.
module ccff_word_serializer #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              active,
    input  logic [CNT_W-1:0]  remaining,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              head,
    output logic              enable
);

    localparam int BL_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic [BL_W-1:0]   take;
    logic              en_q, en_d;

    assign word_ready = active && (bits_left_q == '0) && (remaining != '0);
    assign head       = shreg_q[0];
    assign enable     = en_q;

    always_comb begin
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        // The final word of a pass only contributes the bits the chain still needs.
        if (32'(remaining) < WORD_W) begin
            take = BL_W'(remaining);
        end else begin
            take = BL_W'(WORD_W);
        end

        if (clear) begin
            shreg_d     = '0;
            bits_left_d = '0;
        end else if (en_q) begin
            shreg_d     = shreg_q >> 1;
            bits_left_d = bits_left_q - 1'b1;
        end else if (word_valid && word_ready) begin
            shreg_d     = word_in;
            bits_left_d = take;
        end
        // Enable is its own flop so the chain sees a clean, glitch-free strobe.
        en_d = (bits_left_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q     <= '0;
            bits_left_q <= '0;
            en_q        <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            en_q        <= en_d;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Config-chain loader: streams a bitstream into ccff_head and optionally
// re-streams it while comparing against ccff_tail to confirm the load.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clock,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify_en,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              config_enable,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              pass_ok,
    output logic [CNT_W-1:0]  mismatch_cnt
);

    ccff_ld_state_e   state_q, state_d;
    logic             verify_q, verify_d;
    logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic [CNT_W-1:0] mismatch_q, mismatch_d;
    logic             pass_ok_q, pass_ok_d;
    logic [CNT_W-1:0] remaining;
    logic             ser_clear, ser_active, ser_head, ser_en;

    assign remaining     = CNT_W'(CHAIN_LEN) - shift_cnt_q;
    assign ser_active    = (state_q == LOAD) || (state_q == VERIFY);
    assign ccff_head     = ser_head;
    assign config_enable = ser_en;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FINISH);
    assign pass_ok       = pass_ok_q;
    assign mismatch_cnt  = mismatch_q;

    ccff_word_serializer #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_ser (
        .clk        (prog_clock),
        .rst        (prog_reset),
        .clear      (ser_clear),
        .active     (ser_active),
        .remaining  (remaining),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .head       (ser_head),
        .enable     (ser_en)
    );

    always_comb begin
        state_d     = state_q;
        verify_d    = verify_q;
        shift_cnt_d = shift_cnt_q;
        mismatch_d  = mismatch_q;
        pass_ok_d   = pass_ok_q;
        ser_clear   = 1'b0;

        if (ser_en) begin
            shift_cnt_d = shift_cnt_q + 1'b1;
        end
        // Tail currently holds load-pass bit k while head drives verify-pass bit k.
        if ((state_q == VERIFY) && ser_en && (ccff_tail != ser_head) && (mismatch_q != '1)) begin
            mismatch_d = mismatch_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    verify_d    = verify_en;
                    shift_cnt_d = '0;
                    mismatch_d  = '0;
                    pass_ok_d   = 1'b0;
                    ser_clear   = 1'b1;
                end
            end
            LOAD, VERIFY: begin
                if (abort) begin
                    state_d   = IDLE;
                    pass_ok_d = 1'b0;
                    ser_clear = 1'b1;
                end else if (shift_cnt_q == CNT_W'(CHAIN_LEN)) begin
                    shift_cnt_d = '0;
                    ser_clear   = 1'b1;
                    if ((state_q == LOAD) && verify_q) begin
                        state_d = VERIFY;
                    end else begin
                        state_d   = FINISH;
                        pass_ok_d = verify_q && (mismatch_q == '0);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clock or posedge prog_reset) begin
        if (prog_reset) begin
            state_q     <= IDLE;
            verify_q    <= 1'b0;
            shift_cnt_q <= '0;
            mismatch_q  <= '0;
            pass_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            verify_q    <= verify_d;
            shift_cnt_q <= shift_cnt_d;
            mismatch_q  <= mismatch_d;
            pass_ok_q   <= pass_ok_d;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: 10-flop chain model fed 4-bit words, covering load, verify,
// corrupted verify, underrun, abort, reset mid-load and start/abort interplay.
module tb_ccff_chain_loader;
    import ccff_loader_pkg::*;

    localparam int CL = 10;
    localparam int WW = 4;
    localparam int CW = $clog2(CL + 1);
    localparam logic [CL-1:0] EXP_CHAIN = 10'b1010010111;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          verify_en = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] word_in = '0;
    logic          word_valid = 1'b0;
    logic          word_ready, ccff_head, config_enable, ccff_tail;
    logic          busy, done, pass_ok;
    logic [CW-1:0] mismatch_cnt;
    logic [CL-1:0] chain = '0;

    int errors = 0;
    int checks = 0;
    int shift_total = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int feed_idx = 0;
    int feed_gap = 0;
    int gap_cnt = 0;
    int gap_viol = 0;
    logic [WW-1:0] feed_q[$];

    always #5 clk = ~clk;

    assign ccff_tail = chain[CL-1];

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(CW)) dut (
        .prog_clock    (clk),
        .prog_reset    (rst),
        .start         (start),
        .verify_en     (verify_en),
        .abort         (abort),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .ccff_head     (ccff_head),
        .config_enable (config_enable),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .pass_ok       (pass_ok),
        .mismatch_cnt  (mismatch_cnt)
    );

    // Chain model: head enters flop 0, tail is the last flop.
    always @(posedge clk) begin
        if (config_enable) chain <= {chain[CL-2:0], ccff_head};
    end

    always @(posedge clk) begin
        if (config_enable) shift_total++;
        if (done) done_cnt++;
        if (word_valid && word_ready) begin
            acc_cnt++;
            feed_idx++;
            gap_cnt = 0;
        end
    end

    // Word source: withholds each word for feed_gap ready cycles to model underrun.
    always @(negedge clk) begin
        if (feed_idx < feed_q.size()) begin
            if (word_ready && !word_valid && gap_cnt < feed_gap) begin
                gap_cnt++;
                if (config_enable) gap_viol++;
            end
            word_valid = (gap_cnt >= feed_gap);
            word_in    = feed_q[feed_idx];
        end else begin
            word_valid = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic prep(input int gap);
        feed_idx = 0;
        gap_cnt = 0;
        feed_gap = gap;
        shift_total = 0;
        done_cnt = 0;
        acc_cnt = 0;
        @(negedge clk);
    endtask

    task automatic do_start(input logic v);
        start = 1'b1;
        verify_en = v;
        @(negedge clk);
        start = 1'b0;
        verify_en = 1'b0;
    endtask

    // Returns whether done was seen, outputs on that cycle, and cycles since start.
    task automatic wait_done(output bit seen, output logic pk, output logic [CW-1:0] mc, output int cyc);
        seen = 0; pk = 1'b0; mc = '0; cyc = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1; pk = pass_ok; mc = mismatch_cnt; cyc = t + 2;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_shifts(input int n);
        for (int t = 0; t < 200; t++) begin
            if (shift_total >= n) break;
            @(negedge clk);
        end
        chk("reach_shift", 32'(shift_total >= n), 32'd1);
    endtask

    initial begin
        bit seen;
        logic pk;
        logic [CW-1:0] mc;
        int cyc;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_en", 32'(config_enable), 0);
        chk("rst_ready", 32'(word_ready), 0);
        chk("rst_head", 32'(ccff_head), 0);
        chk("rst_pass", 32'(pass_ok), 0);
        chk("rst_mis", 32'(mismatch_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic load
        feed_q = '{4'h5, 4'hA, 4'h3};
        prep(0);
        do_start(1'b0);
        wait_done(seen, pk, mc, cyc);
        $display("basic: shifts=%0d chain=%b cycles=%0d", shift_total, chain, cyc);
        chk("basic_done", 32'(seen), 1);
        chk("basic_shifts", shift_total, CL);
        chk("basic_chain", 32'(chain), 32'(EXP_CHAIN));
        chk("basic_words", acc_cnt, words_per_pass(CL, WW));
        chk("basic_cycles", cyc, 15);
        chk("basic_pass", 32'(pk), 0);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_idle", 32'(busy), 0);

        // Verify with identical stream
        feed_q = '{4'h5, 4'hA, 4'h3, 4'h5, 4'hA, 4'h3};
        prep(0);
        do_start(1'b1);
        wait_done(seen, pk, mc, cyc);
        $display("verify: shifts=%0d mismatches=%0d pass=%0d", shift_total, mc, pk);
        chk("ver_done", 32'(seen), 1);
        chk("ver_shifts", shift_total, 2 * CL);
        chk("ver_mis", 32'(mc), 0);
        chk("ver_pass_at_done", 32'(pk), 1);
        repeat (3) @(negedge clk);
        chk("ver_pass_held", 32'(pass_ok), 1);
        chk("ver_chain", 32'(chain), 32'(EXP_CHAIN));

        // Verify with bit 3 of the second pass flipped
        feed_q = '{4'h5, 4'hA, 4'h3, 4'hD, 4'hA, 4'h3};
        prep(0);
        do_start(1'b1);
        chk("bad_pass_cleared", 32'(pass_ok), 0);
        wait_done(seen, pk, mc, cyc);
        $display("corrupt: shifts=%0d mismatches=%0d pass=%0d", shift_total, mc, pk);
        chk("bad_done", 32'(seen), 1);
        chk("bad_mis", 32'(mc), 1);
        chk("bad_pass", 32'(pk), 0);

        // Underrun: each word withheld for 5 ready cycles
        feed_q = '{4'h5, 4'hA, 4'h3};
        gap_viol = 0;
        chain = '0;
        prep(5);
        do_start(1'b0);
        wait_done(seen, pk, mc, cyc);
        $display("underrun: shifts=%0d chain=%b cycles=%0d", shift_total, chain, cyc);
        chk("gap_done", 32'(seen), 1);
        chk("gap_en_low", gap_viol, 0);
        chk("gap_shifts", shift_total, CL);
        chk("gap_chain", 32'(chain), 32'(EXP_CHAIN));
        chk("gap_slower", 32'(cyc > 15), 1);

        // Abort at shift 6
        feed_q = '{4'h5, 4'hA, 4'h3};
        prep(0);
        do_start(1'b0);
        wait_shifts(6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        feed_q = {};
        $display("abort: shifts=%0d busy=%0d en=%0d", shift_total, busy, config_enable);
        chk("abort_en", 32'(config_enable), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pass", 32'(pass_ok), 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);

        // Reset mid-load: enable must drop without a clock edge
        feed_q = '{4'h5, 4'hA, 4'h3};
        prep(0);
        do_start(1'b0);
        wait_shifts(3);
        chk("pre_rst_en", 32'(config_enable), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_en", 32'(config_enable), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        feed_q = {};
        repeat (2) @(negedge clk);
        chk("rst_no_done", done_cnt, 0);
        $display("reset: shifts=%0d busy=%0d", shift_total, busy);

        // Normal load after abort and reset
        feed_q = '{4'h5, 4'hA, 4'h3};
        prep(0);
        do_start(1'b0);
        wait_done(seen, pk, mc, cyc);
        $display("reload: shifts=%0d chain=%b", shift_total, chain);
        chk("reload_done", 32'(seen), 1);
        chk("reload_chain", 32'(chain), 32'(EXP_CHAIN));

        // start while busy is ignored
        feed_q = '{4'h5, 4'hA, 4'h3};
        prep(0);
        do_start(1'b0);
        repeat (3) @(negedge clk);
        do_start(1'b1);
        wait_done(seen, pk, mc, cyc);
        $display("busy_start: shifts=%0d pass=%0d", shift_total, pk);
        chk("bs_done", 32'(seen), 1);
        chk("bs_shifts", shift_total, CL);
        chk("bs_pass", 32'(pk), 0);
        chk("bs_done_cnt", done_cnt, 1);

        // start together with abort in IDLE: start wins
        feed_q = '{4'h5, 4'hA, 4'h3};
        prep(0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 1);
        wait_done(seen, pk, mc, cyc);
        $display("start_abort: shifts=%0d chain=%b", shift_total, chain);
        chk("sa_done", 32'(seen), 1);
        chk("sa_chain", 32'(chain), 32'(EXP_CHAIN));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
